// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS inter-stage pipeline registers: stage state
// encoding and the per-boundary widths used when instantiating pipe_stage_reg.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    // IF/ID: PC+4 and fetched instruction; a single "slot live" control bit.
    localparam int IFID_CTRL_W  = 1;
    localparam int IFID_DATA_W  = 64;

    // ID/EX: full control word; PC+4, rs/rt values, sign-extended imm, rt/rd/shamt.
    localparam int IDEX_CTRL_W  = 10;
    localparam int IDEX_DATA_W  = 143;

    // EX/MEM: ALU result, store data, destination register.
    localparam int EXMEM_CTRL_W = 4;
    localparam int EXMEM_DATA_W = 69;

    // MEM/WB: load data, ALU result, destination register.
    localparam int MEMWB_CTRL_W = 2;
    localparam int MEMWB_DATA_W = 69;

endpackage

// File: rtl/pipe_slot.sv
// One valid bit plus one ctrl+data word. Clear drops the valid bit and zeroes
// the ctrl field only; the data field keeps its last value.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 69
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_i,
    input  logic                     clear_i,
    input  logic [CTRL_W+DATA_W-1:0] word_i,
    output logic                     valid_o,
    output logic [CTRL_W+DATA_W-1:0] word_o
);

    localparam int WORD_W = CTRL_W + DATA_W;

    logic              valid_q;
    logic [WORD_W-1:0] word_q;

    // Clear wins over load so a squash can never leave a live beat behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            word_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            word_q  <= {{CTRL_W{1'b0}}, word_q[DATA_W-1:0]};
        end else if (load_i) begin
            valid_q <= 1'b1;
            word_q  <= word_i;
        end
    end

    assign valid_o = valid_q;
    assign word_o  = word_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register between MIPS stages with flush-to-bubble.
// Define PIPE_STAGE_SKID_EN for the skid build (registered in_ready, full rate).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 69
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    localparam int WORD_W = CTRL_W + DATA_W;

    stage_state_e      state_q;
    stage_state_e      state_d;
    logic              accept;
    logic              pop;
    logic              main_load;
    logic              main_clear;
    logic              main_valid;
    logic [WORD_W-1:0] main_word_d;
    logic [WORD_W-1:0] main_word_q;

    assign accept = in_valid && in_ready;
    assign pop    = main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .load_i  (main_load),
        .clear_i (main_clear),
        .word_i  (main_word_d),
        .valid_o (main_valid),
        .word_o  (main_word_q)
    );

`ifdef PIPE_STAGE_SKID_EN

    logic              in_ready_q;
    logic              main_sel_skid;
    logic              skid_load;
    logic              skid_clear;
    logic              skid_valid;
    logic [WORD_W-1:0] skid_word_q;

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .word_i  ({in_ctrl, in_data}),
        .valid_o (skid_valid),
        .word_o  (skid_word_q)
    );

    always_comb begin
        state_d       = state_q;
        main_load     = 1'b0;
        main_clear    = 1'b0;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        if (flush) begin
            // A flush also retires the current output if it is being consumed.
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (pop && accept) begin
                        main_load = 1'b1;
                    end else if (pop) begin
                        main_clear = 1'b1;
                        state_d    = ST_EMPTY;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_d   = ST_TWO;
                    end
                end
                ST_TWO: begin
                    if (pop && skid_valid) begin
                        main_load     = 1'b1;
                        main_sel_skid = 1'b1;
                        skid_clear    = 1'b1;
                        state_d       = ST_ONE;
                    end
                end
                default: begin
                    state_d    = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    assign main_word_d = main_sel_skid ? skid_word_q : {in_ctrl, in_data};

    // Ready is precomputed from the next state so upstream sees a bare flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    assign in_ready = in_ready_q;

`else

    always_comb begin
        state_d    = state_q;
        main_load  = 1'b0;
        main_clear = 1'b0;
        if (flush) begin
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept) begin
                        main_load = 1'b1;
                    end else if (pop) begin
                        main_clear = 1'b1;
                        state_d    = ST_EMPTY;
                    end
                end
                default: begin
                    state_d    = ST_EMPTY;
                    main_clear = 1'b1;
                end
            endcase
        end
    end

    assign main_word_d = {in_ctrl, in_data};

    // Combinational path from out_ready: a freed slot refills in the same cycle.
    assign in_ready = !main_valid || out_ready;

`endif

    assign out_valid = main_valid;
    assign out_ctrl  = main_word_q[WORD_W-1:DATA_W] & {CTRL_W{main_valid}};
    assign out_data  = main_word_q[DATA_W-1:0];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a queue scoreboard; works for both the
// default build and the PIPE_STAGE_SKID_EN build.
module tb_pipe_stage_reg;

    localparam int CW = 4;
    localparam int DW = 69;
    localparam int WW = CW + DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;

    logic [WW-1:0] sb_q[$];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .CTRL_W (CW),
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
    );

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // One clock: compare outputs against the model, update the model from the
    // driven inputs, then advance to 1ns past the next rising edge.
    task automatic step(input string tag, output bit acc);
        bit exp_rdy;
        #1;
`ifdef PIPE_STAGE_SKID_EN
        exp_rdy = (sb_q.size() < 2);
`else
        exp_rdy = (sb_q.size() == 0) || (out_ready === 1'b1);
`endif
        chk($sformatf("%s.out_valid", tag), WW'(out_valid), WW'(sb_q.size() > 0));
        chk($sformatf("%s.in_ready", tag), WW'(in_ready), WW'(exp_rdy));
        if (sb_q.size() > 0) begin
            chk($sformatf("%s.word", tag), {out_ctrl, out_data}, sb_q[0]);
        end else begin
            chk($sformatf("%s.bubble_ctrl", tag), WW'(out_ctrl), '0);
        end
        acc = 1'b0;
        if (reset) begin
            sb_q.delete();
        end else begin
            if (sb_q.size() > 0 && out_ready) void'(sb_q.pop_front());
            if (flush) begin
                sb_q.delete();
            end else if (in_valid && exp_rdy) begin
                sb_q.push_back({in_ctrl, in_data});
                acc = 1'b1;
            end
        end
        $display("step %-10s in_v=%0b in_r=%0b data=%0h out_v=%0b out_r=%0b out=%0h flush=%0b reset=%0b",
                 tag, in_valid, in_ready, in_data, out_valid, out_ready, out_data, flush, reset);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit            acc;
        int            idx;
        logic [DW-1:0] beats[3];
        bit            rdy_pat[8];

        // Reset with a beat offered: nothing may be captured.
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 4'hF;
        in_data   = 69'h1_2345_6789;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", WW'(out_valid), '0);
        chk("rst.out_ctrl", WW'(out_ctrl), '0);
        chk("rst.out_data", WW'(out_data), '0);
        chk("rst.in_ready", WW'(in_ready), WW'(1'b1));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2.out_valid", WW'(out_valid), '0);
        chk("rst2.out_data", WW'(out_data), '0);
        reset    = 1'b0;
        in_valid = 1'b0;
        step("idle", acc);

        // Streaming 1..8 at full rate.
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_ctrl  = CW'(i) | 4'h8;
            in_data  = DW'(i);
            step($sformatf("stream%0d", i), acc);
            chk($sformatf("stream%0d.acc", i), WW'(acc), WW'(1'b1));
        end
        in_valid = 1'b0;
        repeat (2) step("drain", acc);

        // Stall: downstream drops ready while B arrives; hold each beat until taken.
        beats[0] = 69'h0A;
        beats[1] = 69'h0B;
        beats[2] = 69'h0C;
        rdy_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            out_ready = rdy_pat[c];
            in_valid  = (idx < 3);
            in_ctrl   = 4'h5 + CW'(idx);
            in_data   = (idx < 3) ? beats[idx] : '0;
            step($sformatf("stall%0d", c), acc);
            if (acc) idx++;
        end
        chk("stall.all_accepted", WW'(idx), WW'(3));
        chk("stall.drained", WW'(sb_q.size()), '0);

        // Flush while holding beats, with 0x55 offered in the same cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 4'h9;
        in_data   = 69'h21;
        step("fill1", acc);
        in_data   = 69'h22;
        step("fill2", acc);
        flush     = 1'b1;
        in_ctrl   = 4'hF;
        in_data   = 69'h55;
        step("flush", acc);
        chk("flush.no_accept", WW'(acc), '0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        #1;
        chk("postflush.out_valid", WW'(out_valid), '0);
        chk("postflush.out_ctrl", WW'(out_ctrl), '0);
        chk("postflush.in_ready", WW'(in_ready), WW'(1'b1));
        step("postflush", acc);

        // Flush together with out_ready: output consumed, then emptied.
        in_valid  = 1'b1;
        in_ctrl   = 4'h3;
        in_data   = 69'h31;
        step("fill3", acc);
        out_ready = 1'b1;
        flush     = 1'b1;
        in_data   = 69'h55;
        step("flush_pop", acc);
        flush     = 1'b0;
        in_valid  = 1'b0;
        step("after_fp", acc);

        // Reset while holding beats, then 0x77 offered as reset releases.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 4'hA;
        in_data   = 69'h41;
        step("fill4", acc);
        in_data   = 69'h42;
        step("fill5", acc);
        reset     = 1'b1;
        in_ctrl   = 4'hF;
        in_data   = 69'h43;
        step("reset_mid", acc);
        reset     = 1'b0;
        out_ready = 1'b1;
        in_ctrl   = 4'h7;
        in_data   = 69'h77;
        step("offer77", acc);
        chk("offer77.acc", WW'(acc), WW'(1'b1));
        in_valid  = 1'b0;
        #1;
        chk("out77.valid", WW'(out_valid), WW'(1'b1));
        chk("out77.data", WW'(out_data), WW'(69'h77));
        step("out77", acc);
        step("final", acc);
        chk("final.empty", WW'(out_valid), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
